// File: rtl/rst_seq.sv
// rst_seq: power-on / runtime reset sequencer.
// Holds N_CH active-low reset outputs low, waits POR_CYCLES, waits for PLL lock,
// then releases the channels one by one, STAGE_CYCLES apart, ch0 first.
// Lock loss or an external button reset re-asserts every output and restarts.
// Optional build macro RST_SEQ_DEBOUNCE_EN adds a DEBOUNCE_CYCLES low-filter on ext_rst_n.
module rst_seq #(
  parameter int unsigned N_CH            = 3,
  parameter int unsigned POR_CYCLES      = 16,
  parameter int unsigned STAGE_CYCLES    = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 1024
) (
  input  logic            sclk,
  input  logic            rst,
  input  logic            pll_lock,
  input  logic            ext_rst_n,
  output logic [N_CH-1:0] rst_n_o,
  output logic            rst_busy
);

  localparam int unsigned CntMax    = (POR_CYCLES > STAGE_CYCLES) ? POR_CYCLES : STAGE_CYCLES;
  localparam int unsigned CW        = $clog2((CntMax > 2) ? CntMax : 2);
  localparam int unsigned CHW       = $clog2((N_CH > 2) ? N_CH : 2);
  localparam logic [CW-1:0] PorLast   = CW'(POR_CYCLES - 1);
  localparam logic [CW-1:0] StageLast = CW'(STAGE_CYCLES - 1);

  typedef enum logic [1:0] {StPor, StWait, StRel, StRun} state_e;

  // Power-up values match the rst values so no reset pulse is needed after configuration.
  logic [1:0]      lock_sync_q = 2'b00;
  logic [1:0]      ext_sync_q  = 2'b11;
  state_e          state_q     = StPor;
  logic [CW-1:0]   cnt_q       = '0;
  logic [CHW-1:0]  ch_q        = '0;
  logic [N_CH-1:0] rst_n_q     = '0;
  logic            busy_q      = 1'b1;

  state_e          state_d;
  logic [CW-1:0]   cnt_d;
  logic [CHW-1:0]  ch_d;
  logic [N_CH-1:0] rst_n_d;
  logic            busy_d;

  logic lock_s;
  logic ext_s_n;
  logic ext_req;
  logic abort;
  logic rel_first;
  logic rel_next;

  // Two-flop synchronisers for the asynchronous lock and button inputs.
  always_ff @(posedge sclk) begin
    if (rst) begin
      lock_sync_q <= 2'b00;
      ext_sync_q  <= 2'b11;
    end else begin
      lock_sync_q <= {lock_sync_q[0], pll_lock};
      ext_sync_q  <= {ext_sync_q[0], ext_rst_n};
    end
  end

  assign lock_s  = lock_sync_q[1];
  assign ext_s_n = ext_sync_q[1];

`ifdef RST_SEQ_DEBOUNCE_EN
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DebFull = DW'(DEBOUNCE_CYCLES);

  logic [DW-1:0] deb_cnt_q = '0;

  // Count consecutive low cycles of the synced button, saturating at DEBOUNCE_CYCLES.
  always_ff @(posedge sclk) begin
    if (rst) begin
      deb_cnt_q <= '0;
    end else if (ext_s_n) begin
      deb_cnt_q <= '0;
    end else if (deb_cnt_q != DebFull) begin
      deb_cnt_q <= deb_cnt_q + 1'b1;
    end
  end

  // Deasserts combinationally on the first high cycle.
  assign ext_req = ~ext_s_n & (deb_cnt_q == DebFull);
`else
  logic unused_deb_cfg;
  assign unused_deb_cfg = ^DEBOUNCE_CYCLES;
  assign ext_req        = ~ext_s_n;
`endif

  // State, counters and registered outputs.
  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q <= StPor;
      cnt_q   <= '0;
      ch_q    <= '0;
      rst_n_q <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      rst_n_q <= rst_n_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state, counter and channel-index logic; flags release and abort events.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ch_d      = ch_q;
    abort     = 1'b0;
    rel_first = 1'b0;
    rel_next  = 1'b0;
    unique case (state_q)
      StPor: begin
        // Lock is deliberately ignored here; only the button holds the count.
        if (ext_req) begin
          cnt_d = '0;
        end else if (cnt_q == PorLast) begin
          state_d = StWait;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWait: begin
        if (ext_req) begin
          abort = 1'b1;
        end else if (lock_s) begin
          rel_first = 1'b1;
          cnt_d     = '0;
          ch_d      = '0;
          state_d   = (N_CH == 1) ? StRun : StRel;
        end
      end
      StRel: begin
        if (ext_req || !lock_s) begin
          abort = 1'b1;
        end else if (cnt_q == StageLast) begin
          rel_next = 1'b1;
          cnt_d    = '0;
          ch_d     = ch_q + 1'b1;
          if (int'(ch_q) == int'(N_CH) - 2) begin
            state_d = StRun;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (ext_req || !lock_s) begin
          abort = 1'b1;
        end
      end
      default: begin
        abort = 1'b1;
      end
    endcase
    if (abort) begin
      state_d = StPor;
      cnt_d   = '0;
      ch_d    = '0;
    end
  end

  // Output next values: release one more channel per event, drop everything on abort.
  always_comb begin
    rst_n_d = rst_n_q;
    busy_d  = busy_q;
    if (abort) begin
      rst_n_d = '0;
      busy_d  = 1'b1;
    end else if (rel_first) begin
      rst_n_d[0] = 1'b1;
      busy_d     = (N_CH != 1) ? 1'b1 : 1'b0;
    end else if (rel_next) begin
      for (int i = 1; i < int'(N_CH); i++) begin
        if (i == int'(ch_q) + 1) begin
          rst_n_d[i] = 1'b1;
        end
      end
      if (state_d == StRun) begin
        busy_d = 1'b0;
      end
    end
  end

  assign rst_n_o  = rst_n_q;
  assign rst_busy = busy_q;

endmodule
